chacha_keystream_xor: RTL

// - Sits directly downstream of the quarter-round engine (PerformQround).
// - Captures each finished 16-word block and the initial state it was computed from.
// - Adds the two word-wise (RFC 8439 feed-forward) to form the 512-bit keystream block.
// - Streams the keystream out one 32-bit word per handshake, XORed with plaintext words, to produce ciphertext.

---
 rtl/chacha_pkg.sv | 31 +++
 rtl/chacha_keystream_xor_if.sv | 26 ++
 rtl/chacha_ff_add.sv | 20 ++
 rtl/chacha_keystream_xor.sv | 114 +++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha20 keystream/XOR stage: word and matrix types,
// serial word-order helper and the stream FSM encoding.
package chacha_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 16;
    localparam int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK);

    typedef logic [WORD_W-1:0]  word_t;
    typedef word_t [3:0][3:0]   chacha_matrix_t;
    typedef logic [IDX_W-1:0]   word_idx_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } mat_pos_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ks_state_e;

    // Serial word k lives at matrix[3-k/4][3-k%4]; 3-x on two bits is ~x.
    function automatic mat_pos_t mat_idx(input word_idx_t k);
        mat_pos_t p;
        p.row = ~k[3:2];
        p.col = ~k[1:0];
        return p;
    endfunction

endpackage

// File: rtl/chacha_keystream_xor_if.sv
// Plaintext-in / ciphertext-out valid-ready stream of the keystream XOR stage.
interface chacha_keystream_xor_if;
    import chacha_pkg::*;

    word_t pt_data;
    logic  pt_valid;
    logic  pt_last;
    logic  pt_ready;
    word_t ct_data;
    logic  ct_valid;
    logic  ct_last;
    logic  ct_ready;

    // Traffic side: sources plaintext, sinks ciphertext.
    modport master (
        output pt_data, pt_valid, pt_last, ct_ready,
        input  pt_ready, ct_data, ct_valid, ct_last
    );

    // Cipher side: sinks plaintext, sources ciphertext.
    modport slave (
        input  pt_data, pt_valid, pt_last, ct_ready,
        output pt_ready, ct_data, ct_valid, ct_last
    );

endinterface

// File: rtl/chacha_ff_add.sv
// ChaCha20 feed-forward: 16 independent 32-bit adds of initial state and round result.
module chacha_ff_add
    import chacha_pkg::*;
(
    input  chacha_matrix_t init_i,
    input  chacha_matrix_t round_i,
    output chacha_matrix_t ks_o
);

    // Word-wise modular add; carries never cross lanes.
    always_comb begin
        ks_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ks_o[r][c] = init_i[r][c] + round_i[r][c];
            end
        end
    end

endmodule

// File: rtl/chacha_keystream_xor.sv
// ChaCha20 keystream XOR stage: captures a finished block plus its initial
// state, forms the keystream by feed-forward and XORs it word by word onto
// the plaintext stream.
// Optional build macro CHACHA_LE_BYTESWAP_EN: byte-reverse each keystream
// word before the XOR (little-endian serialization); default uses the word as-is.
module chacha_keystream_xor
    import chacha_pkg::*;
#(
    parameter bit ZEROIZE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  chacha_matrix_t         chachamatrixIN,
    input  chacha_matrix_t         chachamatrixOUT,
    input  logic                   blockready,
    output logic                   blk_ack,
    output logic                   block_done,
    chacha_keystream_xor_if.slave  s
);

    chacha_matrix_t ks_sum;
    chacha_matrix_t ks_q;
    ks_state_e      state_q;
    word_idx_t      word_idx_q;
    logic           blk_ack_q;
    logic           block_done_q;
    word_t          ct_data_q;
    logic           ct_valid_q;
    logic           ct_last_q;

    mat_pos_t       pos;
    word_t          ks_word;
    word_t          ks_view;
    logic           pt_ready_c;
    logic           pt_accept;
    logic           last_word;

    chacha_ff_add u_ff_add (
        .init_i  (chachamatrixIN),
        .round_i (chachamatrixOUT),
        .ks_o    (ks_sum)
    );

    // Select the current keystream word and decide acceptance of plaintext.
    always_comb begin
        pos     = mat_idx(word_idx_q);
        ks_word = ks_q[pos.row][pos.col];
`ifdef CHACHA_LE_BYTESWAP_EN
        ks_view = {ks_word[7:0], ks_word[15:8], ks_word[23:16], ks_word[31:24]};
`else
        ks_view = ks_word;
`endif
        pt_ready_c = (state_q == STREAM) && (!ct_valid_q || s.ct_ready);
        pt_accept  = pt_ready_c && s.pt_valid;
        last_word  = (word_idx_q == word_idx_t'(WORDS_PER_BLOCK - 1)) || s.pt_last;
    end

    // Block capture / stream FSM with registered handshake and ciphertext outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            ks_q         <= '0;
            blk_ack_q    <= 1'b0;
            block_done_q <= 1'b0;
            ct_data_q    <= '0;
            ct_valid_q   <= 1'b0;
            ct_last_q    <= 1'b0;
        end else begin
            blk_ack_q    <= 1'b0;
            block_done_q <= 1'b0;
            // Output word drains independently of the FSM; a new accept below overrides.
            if (ct_valid_q && s.ct_ready) begin
                ct_valid_q <= 1'b0;
                ct_last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (blockready) begin
                        ks_q      <= ks_sum;
                        blk_ack_q <= 1'b1;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    if (pt_accept) begin
                        ct_data_q  <= s.pt_data ^ ks_view;
                        ct_valid_q <= 1'b1;
                        ct_last_q  <= s.pt_last;
                        if (last_word) begin
                            block_done_q <= 1'b1;
                            word_idx_q   <= '0;
                            state_q      <= IDLE;
                            if (ZEROIZE) begin
                                ks_q <= '0;
                            end
                        end else begin
                            word_idx_q <= word_idx_q + word_idx_t'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blk_ack    = blk_ack_q;
    assign block_done = block_done_q;
    assign s.pt_ready = pt_ready_c;
    assign s.ct_data  = ct_data_q;
    assign s.ct_valid = ct_valid_q;
    assign s.ct_last  = ct_last_q;

endmodule
